fft_peak_extract: RTL and testbench



---
 rtl/fft_peak_extract.sv | 231 +++++++++++++++++++++++
 tb/tb_fft_peak_extract.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_extract.sv
// rtl/fft_peak_extract.sv - post-FFT |X|^2 DC/peak extractor with bit-serial integer square roots
//
// Purpose: per frame of N FFT bins, square each bin, keep bin 0 (DC) and the
// largest in-window AC bin, then take floor(sqrt()) of both serially.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            bin handshake (transfer = in_valid & in_ready)
//   in_sof, in_chan              bin-0 marker and channel tag (sampled with bin 0)
//   in_re, in_im                 signed FFT bin value
//   out_valid                    one-cycle result strobe
//   out_dc, out_ac, out_bin      DC root, AC peak root, AC peak bin index
//   out_chan                     channel tag of the reported frame
//   err_resync                   one-cycle pulse when a frame restarts early
module fft_peak_extract #(
    parameter int W         = 24,
    parameter int N         = 2048,
    parameter int CH        = 2,
    parameter int AC_START  = 13,
    parameter int AC_STOP   = N / 2 - 1,
    localparam int B        = $clog2(N),
    localparam int C        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sof,
    input  logic [C-1:0] in_chan,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    output logic [W-1:0] out_dc,
    output logic [W-1:0] out_ac,
    output logic [B-1:0] out_bin,
    output logic [C-1:0] out_chan,
    output logic         err_resync
);

    localparam int CW = $clog2(W);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCUM   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_SQRT_DC = 3'd3;
    localparam logic [2:0] S_SQRT_AC = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam logic [B-1:0]  LP_START     = B'(AC_START);
    localparam logic [B-1:0]  LP_STOP      = B'(AC_STOP);
    localparam logic [B-1:0]  LP_LAST      = B'(N - 1);
    localparam logic [CW-1:0] LP_ITER_LAST = CW'(W - 1);

    logic [2:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [B-1:0]   r_bin_cnt;
    logic [C-1:0]   r_chan;
    logic           r_s1_valid, r_s2_valid;
    logic [B-1:0]   r_s1_bin, r_s2_bin;
    logic [2*W-1:0] r_s1_re2, r_s1_im2, r_s2_mag2;
    logic [2*W-1:0] r_dc_mag2, r_peak_mag2;
    logic [B-1:0]   r_peak_bin;
    logic [2*W-1:0] r_rad;
    logic [W+1:0]   r_rem;
    logic [W-1:0]   r_root, r_dc_root;
    logic [W-1:0]   r_out_dc, r_out_ac;
    logic [B-1:0]   r_out_bin;
    logic [C-1:0]   r_out_chan;
    logic           r_err;

    logic                  w_xfer, w_start, w_resync, w_accept;
    logic [B-1:0]          w_idx;
    logic signed [2*W-1:0] w_re_ext, w_im_ext;
    logic [2*W-1:0]        w_re_sq, w_im_sq;
    logic [W+3:0]          w_rem_t, w_trial, w_diff;
    logic                  w_ge;
    logic [W+1:0]          w_rem_next;
    logic [W-1:0]          w_root_next;
    logic                  w_unused_diff;

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_xfer     = in_valid & in_ready;
    assign w_start    = w_xfer & in_sof;
    assign w_resync   = w_start & (r_state == S_ACCUM) & (r_bin_cnt != '0);
    // Outside a frame only a start-of-frame bin is taken into the pipeline.
    assign w_accept   = w_xfer & (in_sof | (r_state == S_ACCUM));
    assign w_idx      = in_sof ? '0 : r_bin_cnt;

    assign w_re_ext   = (2*W)'($signed(in_re));
    assign w_im_ext   = (2*W)'($signed(in_im));
    assign w_re_sq    = w_re_ext * w_re_ext;
    assign w_im_sq    = w_im_ext * w_im_ext;

    // One restoring-sqrt step: bring down two radicand bits, try root*4+1.
    assign w_rem_t       = {r_rem, r_rad[2*W-1 -: 2]};
    assign w_trial       = {2'b00, r_root, 2'b01};
    assign w_ge          = (w_rem_t >= w_trial);
    assign w_diff        = w_rem_t - w_trial;
    assign w_rem_next    = w_ge ? w_diff[W+1:0] : w_rem_t[W+1:0];
    assign w_root_next   = {r_root[W-2:0], w_ge};
    // The remainder never exceeds 2*root, so the top difference bits are always zero.
    assign w_unused_diff = ^w_diff[W+3:W+2];

    assign out_valid  = (r_state == S_OUT);
    assign out_dc     = r_out_dc;
    assign out_ac     = r_out_ac;
    assign out_bin    = r_out_bin;
    assign out_chan   = r_out_chan;
    assign err_resync = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bin_cnt   <= '0;
            r_chan      <= '0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_bin    <= '0;
            r_s2_bin    <= '0;
            r_s1_re2    <= '0;
            r_s1_im2    <= '0;
            r_s2_mag2   <= '0;
            r_dc_mag2   <= '0;
            r_peak_mag2 <= '0;
            r_peak_bin  <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_dc_root   <= '0;
            r_out_dc    <= '0;
            r_out_ac    <= '0;
            r_out_bin   <= '0;
            r_out_chan  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_resync;

            // Stage 1: squares. Stage 2: magnitude. A restart drops whatever
            // the old frame still has in stage 1.
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_bin <= w_idx;
                r_s1_re2 <= w_re_sq;
                r_s1_im2 <= w_im_sq;
            end
            r_s2_valid <= r_s1_valid & ~w_resync;
            r_s2_bin   <= r_s1_bin;
            r_s2_mag2  <= r_s1_re2 + r_s1_im2;

            // Reduction: a frame start wipes the old frame's partial results,
            // including a stage-2 bin that would otherwise land this cycle.
            if (w_start) begin
                r_dc_mag2   <= '0;
                r_peak_mag2 <= '0;
                r_peak_bin  <= LP_START;
                r_chan      <= in_chan;
            end else if (r_s2_valid) begin
                if (r_s2_bin == '0) begin
                    r_dc_mag2 <= r_s2_mag2;
                end
                // Strict compare keeps the lowest index on ties.
                if ((r_s2_bin >= LP_START) && (r_s2_bin <= LP_STOP) &&
                    (r_s2_mag2 > r_peak_mag2)) begin
                    r_peak_mag2 <= r_s2_mag2;
                    r_peak_bin  <= r_s2_bin;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_bin_cnt <= B'(1);
                        r_state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        if (in_sof) begin
                            r_bin_cnt <= B'(1);
                        end else if (r_bin_cnt == LP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_bin_cnt <= r_bin_cnt + B'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last bin pass both pipeline stages.
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_cnt   <= '0;
                        r_rad   <= r_dc_mag2;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_state <= S_SQRT_DC;
                    end
                end
                S_SQRT_DC, S_SQRT_AC: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LP_ITER_LAST) begin
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_root <= '0;
                        if (r_state == S_SQRT_DC) begin
                            r_dc_root <= w_root_next;
                            r_rad     <= r_peak_mag2;
                            r_state   <= S_SQRT_AC;
                        end else begin
                            r_out_dc   <= r_dc_root;
                            r_out_ac   <= w_root_next;
                            r_out_bin  <= r_peak_bin;
                            r_out_chan <= r_chan;
                            r_state    <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_peak_extract.sv
// tb/tb_fft_peak_extract.sv - directed table-driven bench for fft_peak_extract
`timescale 1ns/1ps
module tb_fft_peak_extract;

    localparam int W        = 24;
    localparam int N        = 64;
    localparam int CH       = 2;
    localparam int AC_START = 3;
    localparam int AC_STOP  = N / 2 - 1;
    localparam int B        = 6;
    localparam int C        = 1;
    localparam int P        = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sof = 1'b0;
    logic [C-1:0] in_chan = '0;
    logic [W-1:0] in_re = '0;
    logic [W-1:0] in_im = '0;
    logic         out_valid;
    logic [W-1:0] out_dc;
    logic [W-1:0] out_ac;
    logic [B-1:0] out_bin;
    logic [C-1:0] out_chan;
    logic         err_resync;

    always #(P/2) clk = ~clk;

    fft_peak_extract #(
        .W(W), .N(N), .CH(CH), .AC_START(AC_START), .AC_STOP(AC_STOP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_chan(in_chan),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_dc(out_dc), .out_ac(out_ac), .out_bin(out_bin),
        .out_chan(out_chan), .err_resync(err_resync)
    );

    typedef struct {
        int ch;
        int dc_re, dc_im;
        int pk_bin, pk_re, pk_im;
        int fill_re, fill_im;
        int e_dc, e_ac, e_bin;
    } vec_t;

    typedef struct {
        logic [W-1:0] dc;
        logic [W-1:0] ac;
        logic [B-1:0] bin;
        logic [C-1:0] ch;
        time          t;
    } res_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   fr_re[N];
    int   fr_im[N];
    res_t rq[$];
    int   n_err = 0;
    time  t_err = 0;
    vec_t tbl[6];
    res_t r;
    time  tf, tl;
    int   err0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) rq.push_back('{out_dc, out_ac, out_bin, out_chan, $time});
        if (err_resync === 1'b1) begin
            n_err = n_err + 1;
            t_err = $time;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic send_bin(input int k, input logic [C-1:0] ch, output time t);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = (k == 0);
        in_chan  = ch;
        in_re    = fr_re[k][W-1:0];
        in_im    = fr_im[k][W-1:0];
        while (in_ready !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected ready", g);
        end
        @(posedge clk);
        t = $time;
    endtask

    task automatic send_frame(input logic [C-1:0] ch, input int nb, output time t_first, output time t_last);
        time t;
        t_first = 0;
        t_last  = 0;
        for (int k = 0; k < nb; k++) begin
            send_bin(k, ch, t);
            if (k == 0) t_first = t;
            t_last = t;
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_results(input string name, input int n);
        int g = 0;
        while (rq.size() < n && g < 400) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check(name, rq.size(), n);
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = v.fill_re;
            fr_im[i] = v.fill_im;
        end
        fr_re[0]        = v.dc_re;
        fr_im[0]        = v.dc_im;
        fr_re[v.pk_bin] = v.pk_re;
        fr_im[v.pk_bin] = v.pk_im;
    endtask

    task automatic check_res(input string name, input int e_dc, input int e_ac, input int e_bin, input int e_ch);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            check({name, "_dc"},   r.dc,  e_dc);
            check({name, "_ac"},   r.ac,  e_ac);
            check({name, "_bin"},  r.bin, e_bin);
            check({name, "_chan"}, r.ch,  e_ch);
        end
    endtask

    initial begin
        //            ch  dc_re     dc_im     pk  pk_re     pk_im    fill_re   fill_im   e_dc      e_ac      e_bin
        tbl[0] = '{0, 1000,     0,        5,  300,      400,     0,        0,        1000,     500,      5};
        tbl[1] = '{1, 0,        0,        31, -3,       -4,      0,        0,        0,        5,        31};
        tbl[2] = '{0, -7,       24,       40, 100,      0,       0,        0,        25,       0,        3};
        tbl[3] = '{1, 3,        3,        3,  1,        1,       0,        0,        4,        1,        3};
        tbl[4] = '{0, 6,        8,        10, 2,        0,       2,        0,        10,       2,        3};
        tbl[5] = '{1, -8388608, -8388608, 3,  -8388608, -8388608, -8388608, -8388608, 11863283, 11863283, 3};

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_resync, 0);
        check("rst_out_dc", out_dc, 0);
        check("rst_out_ac", out_ac, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_chan", out_chan, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            build(tbl[i]);
            send_frame(tbl[i].ch[C-1:0], N, tf, tl);
            idle_in();
            wait_results($sformatf("row%0d_count", i), 1);
            if (rq.size() > 0) check($sformatf("row%0d_latency", i), (rq[0].t - tl + P/2) / P, 51);
            check_res($sformatf("row%0d", i), tbl[i].e_dc, tbl[i].e_ac, tbl[i].e_bin, tbl[i].ch);
        end

        // Large but unequal components: floor(sqrt(2^47 - 2^24 + 1)).
        clear_frame();
        fr_re[0]  = 8388607;
        fr_re[17] = -8388608;
        fr_im[17] = 8388607;
        send_frame(1'b0, N, tf, tl);
        idle_in();
        wait_results("big_count", 1);
        check_res("big", 8388607, 11863282, 17, 0);

        // Junk bins while idle, then window edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_re    = 24'd777777;
        end
        clear_frame();
        fr_re[2]           = 10000;
        fr_re[AC_STOP + 1] = 9000;
        fr_re[AC_STOP]     = 50;
        send_frame(1'b1, N, tf, tl);
        idle_in();
        wait_results("edge_count", 1);
        check_res("edge", 0, 50, AC_STOP, 1);

        // Back-to-back channel interleave; in_valid stays high through the stall.
        for (int f = 0; f < 3; f++) begin
            clear_frame();
            fr_re[0] = 7 + f;
            send_frame(C'(f % 2), N, tf, tl);
        end
        idle_in();
        wait_results("ilv_count", 3);
        for (int f = 0; f < 3; f++) check_res($sformatf("ilv%0d", f), 7 + f, 0, AC_START, f % 2);

        // Resync at bin 20; old bins 18/19 still in the pipeline must not leak.
        clear_frame();
        fr_re[0]  = 77;
        fr_re[6]  = 1000;
        fr_re[18] = 5000;
        fr_re[19] = 5000;
        send_frame(1'b1, 20, tf, tl);
        err0 = n_err;
        clear_frame();
        fr_re[0] = 5;
        fr_im[0] = 12;
        fr_re[4] = 30;
        fr_im[4] = 40;
        send_frame(1'b0, N, tf, tl);
        idle_in();
        wait_results("resync_count", 1);
        check("resync_pulses", n_err - err0, 1);
        check("resync_timing", t_err - tf, P/2);
        check_res("resync", 13, 50, 4, 0);

        // Reset during SQRT_AC.
        clear_frame();
        fr_re[0] = 100;
        fr_re[9] = 6;
        fr_im[9] = 8;
        send_frame(1'b1, N, tf, tl);
        idle_in();
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_dc", out_dc, 0);
        check("rstmid_out_ac", out_ac, 0);
        check("rstmid_out_bin", out_bin, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rstmid_no_result", rq.size(), 0);
        send_frame(1'b1, N, tf, tl);
        idle_in();
        wait_results("rstmid_after_count", 1);
        if (rq.size() > 0) check("rstmid_after_latency", (rq[0].t - tl + P/2) / P, 51);
        check_res("rstmid_after", 100, 10, 9, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
